// File: rtl/pipe_de_stage.sv
// ID/EXE boundary: operand bypass select, load-use stall detection, the ID/EXE
// pipeline register with bubble insertion, and a saturating stall-cycle counter.
module pipe_de_stage #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ID_wreg,
  input  logic          ID_m2reg,
  input  logic          ID_wmem,
  input  logic          ID_aluimm,
  input  logic          ID_shift,
  input  logic          ID_jal,
  input  logic [3:0]    ID_aluc,
  input  logic          ID_uses_rs,
  input  logic          ID_uses_rt,
  input  logic [4:0]    ID_rs,
  input  logic [4:0]    ID_rt,
  input  logic [4:0]    ID_write_reg_number,
  input  logic [DW-1:0] ID_qa,
  input  logic [DW-1:0] ID_qb,
  input  logic [DW-1:0] ID_imm,
  input  logic [DW-1:0] ID_pc4,
  input  logic [1:0]    fwd_q1_sel,
  input  logic [1:0]    fwd_q2_sel,
  input  logic [DW-1:0] EXE_alu_result,
  input  logic [DW-1:0] MEM_alu_result,
  input  logic [DW-1:0] MEM_load_data,
  input  logic          EXE_wreg_in,
  input  logic          EXE_m2reg_in,
  input  logic [4:0]    EXE_write_reg_number_in,
  input  logic          flush,
  output logic          stall,
  output logic          EXE_wreg,
  output logic          EXE_m2reg,
  output logic          EXE_wmem,
  output logic          EXE_aluimm,
  output logic          EXE_shift,
  output logic          EXE_jal,
  output logic [3:0]    EXE_aluc,
  output logic [4:0]    EXE_write_reg_number,
  output logic [DW-1:0] EXE_a,
  output logic [DW-1:0] EXE_b,
  output logic [DW-1:0] EXE_imm,
  output logic [DW-1:0] EXE_pc4,
  output logic [CW-1:0] stall_count
);

  logic [DW-1:0] op_a, op_b;
  logic          load_in_exe;
  logic          bubble;

  logic          wreg_q, m2reg_q, wmem_q, aluimm_q, shift_q, jal_q;
  logic          wreg_d, m2reg_d, wmem_d, aluimm_d, shift_d, jal_d;
  logic [3:0]    aluc_q, aluc_d;
  logic [4:0]    wn_q, wn_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d, pc4_q, pc4_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    unique case (fwd_q1_sel)
      2'b00:   op_a = ID_qa;
      2'b01:   op_a = EXE_alu_result;
      2'b10:   op_a = MEM_alu_result;
      default: op_a = MEM_load_data;
    endcase
    unique case (fwd_q2_sel)
      2'b00:   op_b = ID_qb;
      2'b01:   op_b = EXE_alu_result;
      2'b10:   op_b = MEM_alu_result;
      default: op_b = MEM_load_data;
    endcase
  end

  // A load in EXE targeting r0 never produces a value worth waiting for.
  assign load_in_exe = EXE_wreg_in & EXE_m2reg_in & (EXE_write_reg_number_in != 5'd0);
  assign stall = load_in_exe &
                 ((ID_uses_rs & (ID_rs == EXE_write_reg_number_in)) |
                  (ID_uses_rt & (ID_rt == EXE_write_reg_number_in)));
  assign bubble = flush | stall;

  always_comb begin
    wreg_d   = ID_wreg;
    m2reg_d  = ID_m2reg;
    wmem_d   = ID_wmem;
    aluimm_d = ID_aluimm;
    shift_d  = ID_shift;
    jal_d    = ID_jal;
    aluc_d   = ID_aluc;
    wn_d     = ID_write_reg_number;
    a_d      = op_a;
    b_d      = op_b;
    imm_d    = ID_imm;
    pc4_d    = ID_pc4;
    if (bubble) begin
      wreg_d   = 1'b0;
      m2reg_d  = 1'b0;
      wmem_d   = 1'b0;
      aluimm_d = 1'b0;
      shift_d  = 1'b0;
      jal_d    = 1'b0;
      aluc_d   = 4'd0;
      wn_d     = 5'd0;
      a_d      = '0;
      b_d      = '0;
      imm_d    = '0;
      pc4_d    = '0;
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CW{1'b1}})) stall_cnt_d = stall_cnt_q + CW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wreg_q      <= 1'b0;
      m2reg_q     <= 1'b0;
      wmem_q      <= 1'b0;
      aluimm_q    <= 1'b0;
      shift_q     <= 1'b0;
      jal_q       <= 1'b0;
      aluc_q      <= 4'd0;
      wn_q        <= 5'd0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      pc4_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      wreg_q      <= wreg_d;
      m2reg_q     <= m2reg_d;
      wmem_q      <= wmem_d;
      aluimm_q    <= aluimm_d;
      shift_q     <= shift_d;
      jal_q       <= jal_d;
      aluc_q      <= aluc_d;
      wn_q        <= wn_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imm_q       <= imm_d;
      pc4_q       <= pc4_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign EXE_wreg             = wreg_q;
  assign EXE_m2reg            = m2reg_q;
  assign EXE_wmem             = wmem_q;
  assign EXE_aluimm           = aluimm_q;
  assign EXE_shift            = shift_q;
  assign EXE_jal              = jal_q;
  assign EXE_aluc             = aluc_q;
  assign EXE_write_reg_number = wn_q;
  assign EXE_a                = a_q;
  assign EXE_b                = b_q;
  assign EXE_imm              = imm_q;
  assign EXE_pc4              = pc4_q;
  assign stall_count          = stall_cnt_q;

endmodule

// File: tb/tb_pipe_de_stage.sv
// Directed bench for pipe_de_stage: the driver queues hand-computed expectations,
// a monitor checks stall before each edge and the registered outputs after it.
module tb_pipe_de_stage;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ID_wreg, ID_m2reg, ID_wmem, ID_aluimm, ID_shift, ID_jal;
  logic [3:0]    ID_aluc;
  logic          ID_uses_rs, ID_uses_rt;
  logic [4:0]    ID_rs, ID_rt, ID_write_reg_number;
  logic [DW-1:0] ID_qa, ID_qb, ID_imm, ID_pc4;
  logic [1:0]    fwd_q1_sel, fwd_q2_sel;
  logic [DW-1:0] EXE_alu_result, MEM_alu_result, MEM_load_data;
  logic          EXE_wreg_in, EXE_m2reg_in;
  logic [4:0]    EXE_write_reg_number_in;
  logic          flush;
  logic          stall;
  logic          EXE_wreg, EXE_m2reg, EXE_wmem, EXE_aluimm, EXE_shift, EXE_jal;
  logic [3:0]    EXE_aluc;
  logic [4:0]    EXE_write_reg_number;
  logic [DW-1:0] EXE_a, EXE_b, EXE_imm, EXE_pc4;
  logic [CW-1:0] stall_count;

  pipe_de_stage #(.DW(DW), .CW(CW)) dut (
    .clock(clock), .reset(reset),
    .ID_wreg(ID_wreg), .ID_m2reg(ID_m2reg), .ID_wmem(ID_wmem),
    .ID_aluimm(ID_aluimm), .ID_shift(ID_shift), .ID_jal(ID_jal),
    .ID_aluc(ID_aluc), .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_write_reg_number(ID_write_reg_number),
    .ID_qa(ID_qa), .ID_qb(ID_qb), .ID_imm(ID_imm), .ID_pc4(ID_pc4),
    .fwd_q1_sel(fwd_q1_sel), .fwd_q2_sel(fwd_q2_sel),
    .EXE_alu_result(EXE_alu_result), .MEM_alu_result(MEM_alu_result),
    .MEM_load_data(MEM_load_data),
    .EXE_wreg_in(EXE_wreg_in), .EXE_m2reg_in(EXE_m2reg_in),
    .EXE_write_reg_number_in(EXE_write_reg_number_in),
    .flush(flush), .stall(stall),
    .EXE_wreg(EXE_wreg), .EXE_m2reg(EXE_m2reg), .EXE_wmem(EXE_wmem),
    .EXE_aluimm(EXE_aluimm), .EXE_shift(EXE_shift), .EXE_jal(EXE_jal),
    .EXE_aluc(EXE_aluc), .EXE_write_reg_number(EXE_write_reg_number),
    .EXE_a(EXE_a), .EXE_b(EXE_b), .EXE_imm(EXE_imm), .EXE_pc4(EXE_pc4),
    .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        stall;
    logic [5:0]  ctl;
    logic [3:0]  aluc;
    logic [4:0]  wn;
    logic [31:0] a, b, imm, pc4;
    logic [3:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [5:0] dut_ctl();
    return {EXE_wreg, EXE_m2reg, EXE_wmem, EXE_aluimm, EXE_shift, EXE_jal};
  endfunction

  task automatic chk_all_zero(input string name);
    chk({name, ".ctl"}, 32'(dut_ctl()), 32'd0);
    chk({name, ".aluc"}, 32'(EXE_aluc), 32'd0);
    chk({name, ".wn"}, 32'(EXE_write_reg_number), 32'd0);
    chk({name, ".a"}, EXE_a, 32'd0);
    chk({name, ".b"}, EXE_b, 32'd0);
    chk({name, ".imm"}, EXE_imm, 32'd0);
    chk({name, ".pc4"}, EXE_pc4, 32'd0);
    chk({name, ".cnt"}, 32'(stall_count), 32'd0);
  endtask

  // Monitor: stall sampled 1 ns before the edge, registers 1 ns after it.
  initial begin
    logic s_stall;
    exp_t e;
    forever begin
      @(negedge clock);
      #4 s_stall = stall;
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.name, ".stall"}, 32'(s_stall), 32'(e.stall));
        chk({e.name, ".ctl"}, 32'(dut_ctl()), 32'(e.ctl));
        chk({e.name, ".aluc"}, 32'(EXE_aluc), 32'(e.aluc));
        chk({e.name, ".wn"}, 32'(EXE_write_reg_number), 32'(e.wn));
        chk({e.name, ".a"}, EXE_a, e.a);
        chk({e.name, ".b"}, EXE_b, e.b);
        chk({e.name, ".imm"}, EXE_imm, e.imm);
        chk({e.name, ".pc4"}, EXE_pc4, e.pc4);
        chk({e.name, ".cnt"}, 32'(stall_count), 32'(e.cnt));
      end
    end
  end

  // Baseline ALU instruction with no hazard: r3 = r1 op r2.
  task automatic set_default();
    ID_wreg = 1'b1; ID_m2reg = 1'b0; ID_wmem = 1'b0;
    ID_aluimm = 1'b1; ID_shift = 1'b0; ID_jal = 1'b0; ID_aluc = 4'h3;
    ID_uses_rs = 1'b1; ID_uses_rt = 1'b1;
    ID_rs = 5'd1; ID_rt = 5'd2; ID_write_reg_number = 5'd3;
    ID_qa = 32'h11; ID_qb = 32'h55; ID_imm = 32'h66; ID_pc4 = 32'h100;
    fwd_q1_sel = 2'b00; fwd_q2_sel = 2'b00;
    EXE_alu_result = 32'h22; MEM_alu_result = 32'h33; MEM_load_data = 32'h44;
    EXE_wreg_in = 1'b0; EXE_m2reg_in = 1'b0; EXE_write_reg_number_in = 5'd0;
    flush = 1'b0;
  endtask

  // Queue one expectation. Captured controls are the values this bench drove.
  task automatic issue(input string name, input logic e_stall, input logic bub,
                       input logic [31:0] e_a, input logic [31:0] e_b, input logic [3:0] e_cnt);
    exp_t e;
    e.name  = name;
    e.stall = e_stall;
    e.cnt   = e_cnt;
    if (bub) begin
      e.ctl = 6'd0; e.aluc = 4'd0; e.wn = 5'd0;
      e.a = 32'd0; e.b = 32'd0; e.imm = 32'd0; e.pc4 = 32'd0;
    end else begin
      e.ctl  = {ID_wreg, ID_m2reg, ID_wmem, ID_aluimm, ID_shift, ID_jal};
      e.aluc = ID_aluc;
      e.wn   = ID_write_reg_number;
      e.a = e_a; e.b = e_b; e.imm = ID_imm; e.pc4 = ID_pc4;
    end
    exp_q.push_back(e);
  endtask

  task automatic load_r5_in_exe();
    EXE_wreg_in = 1'b1; EXE_m2reg_in = 1'b1; EXE_write_reg_number_in = 5'd5;
  endtask

  initial begin
    set_default();
    #2;
    chk_all_zero("reset_state");
    @(negedge clock);
    reset = 1'b0;

    set_default(); fwd_q2_sel = 2'b11;
    issue("fwd00", 1'b0, 1'b0, 32'h11, 32'h44, 4'd0);
    @(negedge clock);
    set_default(); fwd_q1_sel = 2'b01; fwd_q2_sel = 2'b10;
    issue("fwd01", 1'b0, 1'b0, 32'h22, 32'h33, 4'd0);
    @(negedge clock);
    set_default(); fwd_q1_sel = 2'b10; fwd_q2_sel = 2'b01;
    issue("fwd10", 1'b0, 1'b0, 32'h33, 32'h22, 4'd0);
    @(negedge clock);
    set_default(); fwd_q1_sel = 2'b11;
    issue("fwd11", 1'b0, 1'b0, 32'h44, 32'h55, 4'd0);

    @(negedge clock);
    set_default(); load_r5_in_exe(); ID_rs = 5'd5;
    issue("loaduse_rs", 1'b1, 1'b1, 32'h0, 32'h0, 4'd1);
    @(negedge clock);
    set_default(); load_r5_in_exe(); ID_rs = 5'd5; ID_uses_rs = 1'b0;
    issue("rs_unused", 1'b0, 1'b0, 32'h11, 32'h55, 4'd1);
    @(negedge clock);
    set_default(); load_r5_in_exe(); ID_rt = 5'd5;
    issue("loaduse_rt", 1'b1, 1'b1, 32'h0, 32'h0, 4'd2);
    @(negedge clock);
    set_default(); EXE_wreg_in = 1'b1; EXE_m2reg_in = 1'b1; ID_rs = 5'd0;
    issue("load_r0", 1'b0, 1'b0, 32'h11, 32'h55, 4'd2);
    @(negedge clock);
    set_default(); EXE_wreg_in = 1'b1; EXE_write_reg_number_in = 5'd5; ID_rs = 5'd5;
    issue("alu_producer", 1'b0, 1'b0, 32'h11, 32'h55, 4'd2);

    @(negedge clock);
    set_default(); ID_wreg = 1'b0; ID_wmem = 1'b1; flush = 1'b1;
    issue("flush_sw", 1'b0, 1'b1, 32'h0, 32'h0, 4'd2);
    @(negedge clock);
    set_default(); load_r5_in_exe(); ID_rs = 5'd5; flush = 1'b1;
    issue("flush_stall", 1'b1, 1'b1, 32'h0, 32'h0, 4'd3);

    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      set_default(); load_r5_in_exe(); ID_rs = 5'd5;
      issue($sformatf("sat%0d", i), 1'b1, 1'b1, 32'h0, 32'h0, (i + 4 > 15) ? 4'd15 : 4'(i + 4));
    end

    @(negedge clock);
    set_default(); fwd_q1_sel = 2'b11;
    issue("after_hazard", 1'b0, 1'b0, 32'h44, 32'h55, 4'd15);
    @(posedge clock);
    #2;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d expectations still queued, expected 0", exp_q.size());
    end
    chk("pre_reset.a_nonzero", 32'(EXE_a != 32'd0), 32'd1);
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset");

    @(negedge clock);
    reset = 1'b0;
    set_default(); fwd_q1_sel = 2'b10;
    issue("post_reset", 1'b0, 1'b0, 32'h33, 32'h55, 4'd0);

    for (int n = 0; n < 20 && exp_q.size() > 0; n++) @(posedge clock);
    #3;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout: %0d expectations unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_de_stage.md
Name: pipe_de_stage

Overview:
- ID-to-EXE boundary of the 5-stage pipelined CPU. Consumes the 2-bit forward select codes produced by the forwarding controller.
- Selects the final ID operands from the register file or one of the bypass paths.
- Detects load-use hazards and raises stall toward PC and IF/ID.
- Holds the ID/EXE pipeline register, inserting a bubble on stall or flush.
- Keeps a saturating stall counter for performance measurement.

Parameters:
- DW, 32, datapath width
- CW, 16, stall counter width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- ID_wreg, ID_m2reg, ID_wmem, ID_aluimm, ID_shift, ID_jal  in  1 each  decoded ID controls
- ID_aluc  in  4  ALU op
- ID_uses_rs, ID_uses_rt  in  1 each  instruction actually reads rs / rt
- ID_rs, ID_rt, ID_write_reg_number  in  5 each  register numbers
- ID_qa, ID_qb  in  DW each  register-file read data
- ID_imm, ID_pc4  in  DW each  extended immediate, PC+4
- fwd_q1_sel, fwd_q2_sel  in  2 each  forward select codes (00 regfile, 01 EXE ALU, 10 MEM ALU, 11 MEM load data)
- EXE_alu_result, MEM_alu_result, MEM_load_data  in  DW each  bypass sources
- EXE_wreg_in, EXE_m2reg_in  in  1 each  current EXE-stage controls (fed back from own outputs)
- EXE_write_reg_number_in  in  5  current EXE-stage destination
- flush  in  1  branch/jump taken; squash ID instruction
- stall  out  1  combinational; hold PC and IF/ID
- EXE_wreg, EXE_m2reg, EXE_wmem, EXE_aluimm, EXE_shift, EXE_jal  out  1 each  registered controls
- EXE_aluc  out  4  registered ALU op
- EXE_write_reg_number  out  5  registered destination
- EXE_a, EXE_b, EXE_imm, EXE_pc4  out  DW each  registered operands
- stall_count  out  CW  saturating count of stall cycles

Behaviour:
- Operand mux (combinational), per operand: 00→ID_qa/ID_qb; 01→EXE_alu_result; 10→MEM_alu_result; 11→MEM_load_data.
- Load-use hazard. stall=1 when EXE_wreg_in & EXE_m2reg_in & EXE_write_reg_number_in≠0 and either:
  - ID_uses_rs & rs==EXE_write_reg_number_in, or
  - ID_uses_rt & rt==EXE_write_reg_number_in.
- Otherwise stall=0.
- stall is purely combinational and has no dependence on flush.
- Register update on each rising edge, highest priority first:
  1. reset: all EXE_* outputs clear to 0 and stall_count clears to 0, asynchronously.
  2. flush=1: bubble. All EXE_* controls and EXE_write_reg_number are 0. Data outputs EXE_a, EXE_b, EXE_imm, EXE_pc4 are 0.
  3. stall=1 (no flush): same bubble as flush.
  4. else: all ID_* controls, selected operands, ID_imm, ID_pc4 and ID_write_reg_number are captured.
- A bubble has EXE_wreg=0 and EXE_wmem=0, so it writes no architectural state.
- Simultaneous flush and stall: a bubble is inserted and stall still asserts to the front end. Front-end redirect overrides the hold.
- stall_count:
  - Increments by 1 on each edge with stall=1 (flush irrelevant).
  - Saturates at all-ones (2^CW-1) and never wraps.
  - Holds otherwise.
- Latency: one cycle ID→EXE. A load-use stall lasts exactly one cycle, because the load moves to MEM and then forwards via code 11.
- Reset deasserting mid-operation: the first post-reset edge captures ID normally. No residual stall state exists.
- rs/rt == 0 never triggers a stall.

Test Plan:
- Forward select:
  - Setup: ID_qa=0x11, EXE_alu_result=0x22, MEM_alu_result=0x33, MEM_load_data=0x44, no hazard.
  - Stimulus: step fwd_q1_sel 00,01,10,11.
  - Required: EXE_a is 0x11, 0x22, 0x33, 0x44 one edge after each code.
- Load-use:
  - Stimulus: EXE_wreg_in=1, EXE_m2reg_in=1, EXE_write_reg_number_in=5; ID_rs=5, ID_uses_rs=1.
  - Required: stall=1 the same cycle; next edge EXE_wreg=0, EXE_wmem=0, EXE_a=0; stall_count=1.
  - Stimulus: with ID_uses_rs=0, repeat.
  - Required: no stall.
- Register 0 and ALU producer:
  - Stimulus: EXE_write_reg_number_in=0 with load.
  - Required: stall=0.
  - Stimulus: EXE_m2reg_in=0, matching rs.
  - Required: stall=0.
- Flush:
  - Stimulus: flush=1 with a valid ID sw (ID_wmem=1).
  - Required: next edge EXE_wmem=0 and all controls 0.
  - Stimulus: flush+stall together.
  - Required: bubble inserted, stall=1.
- Counter saturation:
  - Stimulus: CW=4, hold hazard for 20 cycles.
  - Required: stall_count stops at 15 and does not wrap.
- Async reset:
  - Stimulus: assert reset mid-cycle between edges with nonzero outputs.
  - Required: EXE_* outputs and stall_count go to 0 immediately, without waiting for a clock edge.
